// File: rtl/regfile_pkg.sv
// Shared constants and port-packing helpers for the multi-port register file.
package regfile_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NUM_RD = 2;
    localparam int RF_NUM_WR = 2;

    // Bit offset of lane idx inside a flat bus of width-bit lanes.
    function automatic int sliceLsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// One read port: write/reservation bypass, zero-register masking, output register.
// Latency 1 cycle; rdEn=0 holds rdData/rdBusy (stall).
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        rdEn,
    input  logic [ADDR_W-1:0]           rdAddr,
    input  logic [DATA_W-1:0]           storedData,
    input  logic                        storedBusy,
    input  logic [RF_NUM_WR-1:0]        wrEn,
    input  logic [RF_NUM_WR*ADDR_W-1:0] wrAddr,
    input  logic [RF_NUM_WR*DATA_W-1:0] wrData,
    input  logic                        rsvEn,
    input  logic [ADDR_W-1:0]           rsvAddr,
    output logic [DATA_W-1:0]           rdData,
    output logic                        rdBusy
);

    localparam int WA0 = sliceLsb(0, ADDR_W);
    localparam int WA1 = sliceLsb(1, ADDR_W);
    localparam int WD0 = sliceLsb(0, DATA_W);
    localparam int WD1 = sliceLsb(1, DATA_W);

    logic              isZeroReg;
    logic              wrHit0;
    logic              wrHit1;
    logic              rsvHit;
    logic [DATA_W-1:0] nextData;
    logic              nextBusy;

    // Reproduce the entry's post-edge state: port 1 over port 0 over storage,
    // and a same-edge reservation beats the write's busy clear.
    always_comb begin
        isZeroReg = (ZERO_REG != 0) && (rdAddr == '0);
        wrHit0    = wrEn[0] && (wrAddr[WA0 +: ADDR_W] == rdAddr);
        wrHit1    = wrEn[1] && (wrAddr[WA1 +: ADDR_W] == rdAddr);
        rsvHit    = rsvEn && (rsvAddr == rdAddr);

        nextData = storedData;
        nextBusy = storedBusy;
        if (wrHit1) begin
            nextData = wrData[WD1 +: DATA_W];
        end else if (wrHit0) begin
            nextData = wrData[WD0 +: DATA_W];
        end
        if (rsvHit) begin
            nextBusy = 1'b1;
        end else if (wrHit0 || wrHit1) begin
            nextBusy = 1'b0;
        end
        if (isZeroReg) begin
            nextData = '0;
            nextBusy = 1'b0;
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            rdData <= '0;
            rdBusy <= 1'b0;
        end else if (rdEn) begin
            rdData <= nextData;
            rdBusy <= nextBusy;
        end
    end

endmodule

// File: rtl/regfile_mp.sv
// Register file: 2 write ports, NUM_RD registered read ports, busy scoreboard.
// Read latency 1 cycle with write bypass; rd_en=0 stalls read outputs only.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = RF_NUM_RD,
    parameter int ZERO_REG = 1
) (
    input  logic                        CLOCK,
    input  logic                        RESET,
    input  logic                        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]    rd_addr,
    output logic [NUM_RD*DATA_W-1:0]    rd_data,
    output logic [NUM_RD-1:0]           rd_busy,
    input  logic [RF_NUM_WR-1:0]        wr_en,
    input  logic [RF_NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [RF_NUM_WR*DATA_W-1:0] wr_data,
    input  logic                        rsv_en,
    input  logic [ADDR_W-1:0]           rsv_addr,
    output logic                        wr_conflict
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int WA1   = sliceLsb(1, ADDR_W);
    localparam int WD1   = sliceLsb(1, DATA_W);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    logic [ADDR_W-1:0] wrAddr0;
    logic [ADDR_W-1:0] wrAddr1;
    logic [DATA_W-1:0] wrData0;
    logic [DATA_W-1:0] wrData1;
    logic [DEPTH-1:0]  wrHit0;
    logic [DEPTH-1:0]  wrHit1;
    logic [DEPTH-1:0]  rsvHit;
    logic              conflictNext;

    assign wrAddr0 = wr_addr[0 +: ADDR_W];
    assign wrAddr1 = wr_addr[WA1 +: ADDR_W];
    assign wrData0 = wr_data[0 +: DATA_W];
    assign wrData1 = wr_data[WD1 +: DATA_W];

    function automatic logic isWritable(input int a);
        return !((ZERO_REG != 0) && (a == 0));
    endfunction

    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            wrHit0[a] = isWritable(a) && wr_en[0] && (wrAddr0 == ADDR_W'(a));
            wrHit1[a] = isWritable(a) && wr_en[1] && (wrAddr1 == ADDR_W'(a));
            rsvHit[a] = isWritable(a) && rsv_en && (rsv_addr == ADDR_W'(a));
        end
    end

    // A collision on the hard-wired zero entry is not a conflict: nothing commits.
    always_comb begin
        conflictNext = wr_en[0] && wr_en[1] && (wrAddr0 == wrAddr1)
                       && !((ZERO_REG != 0) && (wrAddr0 == '0));
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            for (int a = 0; a < DEPTH; a++) begin
                regs[a] <= '0;
            end
            busy <= '0;
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wrHit1[a]) begin
                    regs[a] <= wrData1;
                end else if (wrHit0[a]) begin
                    regs[a] <= wrData0;
                end
                if (rsvHit[a]) begin
                    busy[a] <= 1'b1;
                end else if (wrHit0[a] || wrHit1[a]) begin
                    busy[a] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            wr_conflict <= 1'b0;
        end else begin
            wr_conflict <= conflictNext;
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : gRdPort
        logic [ADDR_W-1:0] portAddr;
        assign portAddr = rd_addr[sliceLsb(i, ADDR_W) +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .ZERO_REG (ZERO_REG)
        ) uReadPort (
            .CLOCK      (CLOCK),
            .RESET      (RESET),
            .rdEn       (rd_en),
            .rdAddr     (portAddr),
            .storedData (regs[portAddr]),
            .storedBusy (busy[portAddr]),
            .wrEn       (wr_en),
            .wrAddr     (wr_addr),
            .wrData     (wr_data),
            .rsvEn      (rsv_en),
            .rsvAddr    (rsv_addr),
            .rdData     (rd_data[sliceLsb(i, DATA_W) +: DATA_W]),
            .rdBusy     (rd_busy[i])
        );
    end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp against a sequential array model.
module tb_regfile_mp;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_RD = 2;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic                     CLOCK = 1'b0;
    logic                     RESET = 1'b1;
    logic                     rdEn;
    logic [NUM_RD*ADDR_W-1:0] rdAddr;
    logic [NUM_RD*DATA_W-1:0] rdData;
    logic [NUM_RD-1:0]        rdBusy;
    logic [1:0]               wrEn;
    logic [2*ADDR_W-1:0]      wrAddr;
    logic [2*DATA_W-1:0]      wrData;
    logic                     rsvEn;
    logic [ADDR_W-1:0]        rsvAddr;
    logic                     wrConflict;

    regfile_mp #(
        .DATA_W   (DATA_W),
        .ADDR_W   (ADDR_W),
        .NUM_RD   (NUM_RD),
        .ZERO_REG (1)
    ) dut (
        .CLOCK       (CLOCK),
        .RESET       (RESET),
        .rd_en       (rdEn),
        .rd_addr     (rdAddr),
        .rd_data     (rdData),
        .rd_busy     (rdBusy),
        .wr_en       (wrEn),
        .wr_addr     (wrAddr),
        .wr_data     (wrData),
        .rsv_en      (rsvEn),
        .rsv_addr    (rsvAddr),
        .wr_conflict (wrConflict)
    );

    always #5 CLOCK = ~CLOCK;

    // Reference state: register contents and busy flags as plain arrays.
    logic [DATA_W-1:0] mData [DEPTH];
    bit                mBusy [DEPTH];
    logic [DATA_W-1:0] expData [NUM_RD];
    bit                expBusy [NUM_RD];
    bit                expConf;

    int nChecks = 0;
    int nFails  = 0;

    task automatic checkEq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit writable(input int a);
        return a != 0;
    endfunction

    task automatic modelReset();
        for (int a = 0; a < DEPTH; a++) begin
            mData[a] = '0;
            mBusy[a] = 0;
        end
        for (int i = 0; i < NUM_RD; i++) begin
            expData[i] = '0;
            expBusy[i] = 0;
        end
        expConf = 0;
    endtask

    // Apply one clock edge: writes in port order, busy clears, then reservation,
    // then reads observe the resulting state.
    task automatic modelStep();
        int a0, a1, ra;
        a0 = int'(wrAddr[0 +: ADDR_W]);
        a1 = int'(wrAddr[ADDR_W +: ADDR_W]);
        ra = int'(rsvAddr);
        if (wrEn[0] && writable(a0)) begin
            mData[a0] = wrData[0 +: DATA_W];
            mBusy[a0] = 0;
        end
        if (wrEn[1] && writable(a1)) begin
            mData[a1] = wrData[DATA_W +: DATA_W];
            mBusy[a1] = 0;
        end
        if (rsvEn && writable(ra)) mBusy[ra] = 1;
        expConf = (wrEn == 2'b11) && (a0 == a1) && writable(a0);
        if (rdEn) begin
            for (int i = 0; i < NUM_RD; i++) begin
                int a;
                a = int'(rdAddr[i*ADDR_W +: ADDR_W]);
                expData[i] = writable(a) ? mData[a] : '0;
                expBusy[i] = writable(a) ? mBusy[a] : 0;
            end
        end
    endtask

    task automatic checkOutputs();
        for (int i = 0; i < NUM_RD; i++) begin
            checkEq($sformatf("rd_data%0d", i), 64'(rdData[i*DATA_W +: DATA_W]), 64'(expData[i]));
            checkEq($sformatf("rd_busy%0d", i), 64'(rdBusy[i]), 64'(expBusy[i]));
        end
        checkEq("wr_conflict", 64'(wrConflict), 64'(expConf));
    endtask

    task automatic tick();
        @(posedge CLOCK);
        modelStep();
        #1;
        checkOutputs();
    endtask

    task automatic setIdle();
        rdEn = 0; rdAddr = '0; wrEn = 2'b00; wrAddr = '0; wrData = '0; rsvEn = 0; rsvAddr = '0;
    endtask

    task automatic cyc(input logic [1:0] we, input int wa0, input logic [31:0] wd0,
                       input int wa1, input logic [31:0] wd1, input bit re,
                       input int ra0, input int ra1, input bit rv, input int rva);
        wrEn = we;
        wrAddr = {ADDR_W'(wa1), ADDR_W'(wa0)};
        wrData = {wd1, wd0};
        rdEn = re;
        rdAddr = {ADDR_W'(ra1), ADDR_W'(ra0)};
        rsvEn = rv;
        rsvAddr = ADDR_W'(rva);
        tick();
    endtask

    // Called 1 time unit after an edge: reset rises mid-cycle with busy inputs
    // applied, holds over one edge, and falls mid-cycle with idle inputs.
    task automatic pulseReset();
        #2;
        RESET = 1;
        wrEn = 2'b11; wrAddr = {5'd4, 5'd6}; wrData = {32'hCAFE0001, 32'hCAFE0002};
        rsvEn = 1; rsvAddr = 5'd6; rdEn = 1; rdAddr = {5'd4, 5'd6};
        #1;
        modelReset();
        checkOutputs();
        @(posedge CLOCK);
        #2;
        checkOutputs();
        setIdle();
        RESET = 0;
    endtask

    initial begin
        setIdle();
        modelReset();
        #1;
        checkOutputs();
        #11;
        RESET = 0;

        // Write r5, read it back, then reset mid-cycle: the value must not survive.
        cyc(2'b01, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0);
        cyc(2'b00, 0, 0, 0, 0, 1, 5, 5, 0, 0);
        checkEq("r5_before_reset", 64'(rdData[31:0]), 64'h0000_0000_DEAD_BEEF);
        pulseReset();
        cyc(2'b00, 0, 0, 0, 0, 1, 5, 5, 0, 0);
        checkEq("r5_after_reset", 64'(rdData[31:0]), 64'h0);
        checkEq("r5_busy_after_reset", 64'(rdBusy), 64'h0);

        // Write-to-read bypass on the same edge.
        cyc(2'b01, 3, 32'h1234, 0, 0, 1, 3, 0, 0, 0);
        checkEq("bypass", 64'(rdData[31:0]), 64'h1234);

        // Dual write to r7: port 1 wins, conflict flag for one cycle only.
        cyc(2'b11, 7, 32'hAAAA, 7, 32'h5555, 0, 0, 0, 0, 0);
        checkEq("conflict_set", 64'(wrConflict), 64'h1);
        cyc(2'b00, 0, 0, 0, 0, 1, 7, 7, 0, 0);
        checkEq("conflict_clear", 64'(wrConflict), 64'h0);
        checkEq("r7_port1_wins", 64'(rdData[63:32]), 64'h5555);

        // Zero register ignores writes and reservations.
        cyc(2'b11, 0, 32'hFFFFFFFF, 0, 32'hFFFFFFFF, 1, 0, 0, 1, 0);
        checkEq("zero_conflict", 64'(wrConflict), 64'h0);
        cyc(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        checkEq("zero_data", 64'(rdData), 64'h0);
        checkEq("zero_busy", 64'(rdBusy), 64'h0);

        // Scoreboard: reservation, same-edge write+reserve, then plain write.
        cyc(2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 9);
        cyc(2'b00, 0, 0, 0, 0, 1, 9, 9, 0, 0);
        checkEq("r9_reserved", 64'(rdBusy), 64'h3);
        cyc(2'b01, 9, 32'h42, 0, 0, 1, 9, 0, 1, 9);
        checkEq("r9_rsv_wins", 64'(rdBusy[0]), 64'h1);
        cyc(2'b01, 9, 32'h42, 0, 0, 1, 9, 9, 0, 0);
        checkEq("r9_cleared", 64'(rdBusy), 64'h0);
        checkEq("r9_data", 64'(rdData[31:0]), 64'h42);

        // Stall: outputs hold while r2 is rewritten.
        cyc(2'b01, 2, 32'h7, 0, 0, 1, 2, 2, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(2'b01, 2, 32'h10, 0, 0, 0, 2, 2, 0, 0);
            checkEq("stall_hold", 64'(rdData[31:0]), 64'h7);
        end
        cyc(2'b00, 0, 0, 0, 0, 1, 2, 2, 0, 0);
        checkEq("stall_release", 64'(rdData[31:0]), 64'h10);

        // Random traffic, biased toward a few low addresses to force collisions.
        for (int n = 0; n < 400; n++) begin
            logic [1:0] we;
            int wa0, wa1, ra0, ra1, rva;
            we  = 2'($urandom_range(0, 3));
            wa0 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
            wa1 = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(0, DEPTH - 1);
            ra0 = $urandom_range(0, 7);
            ra1 = ($urandom_range(0, 3) == 0) ? ra0 : $urandom_range(0, 7);
            rva = $urandom_range(0, 7);
            cyc(we, wa0, $urandom, wa1, $urandom, ($urandom_range(0, 3) != 0),
                ra0, ra1, ($urandom_range(0, 2) == 0), rva);
            if ($urandom_range(0, 99) == 0) pulseReset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
